// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB4 requester turning a valid/ready command stream (cmd_*) into APB transfers (p*) with one registered response (rsp_*) per command; clock pclk, async active-low reset preset
module apb_master_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16,
  parameter logic [2:0] PROT = 3'b000
)(
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic done, abort, accept;
  assign pprot = PROT;
  always_comb begin
    done = state == ACCESS && pready;
    abort = state == ACCESS && !pready && TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    cmd_ready = state == IDLE || done || abort;
    accept = cmd_valid && cmd_ready;
    state_nx = accept ? SETUP : state == SETUP ? ACCESS : (done || abort) ? IDLE : state;
    psel = state != IDLE;
    penable = state == ACCESS;
  end
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state <= IDLE;
      cnt <= '0;
      paddr <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == SETUP ? '0 : (state == ACCESS && !pready && cnt != '1) ? cnt + 1'b1 : cnt;
      if (accept) begin
        paddr <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
        pstrb <= cmd_write ? cmd_strb : '0;
      end
      rsp_valid <= done || abort;
      rsp_rdata <= (done && !pwrite) ? prdata : '0;
      rsp_err <= done ? pslverr : abort;
      rsp_timeout <= abort;
    end
  end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: randomized scoreboard bench for apb_master_ctrl with an APB slave model
module tb_apb_master_ctrl;
  localparam int TO = 4;
  localparam logic [2:0] PR = 3'b101;
  logic pclk = 0, preset;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0] cmd_strb;
  logic rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0] pstrb;
  logic [2:0] pprot;
  logic pready, pslverr;
  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .PROT(PR)) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr));
  always #5 pclk = ~pclk;
  typedef struct {
    logic wr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] strb;
    logic err;
    int w, gap;
  } cmd_t;
  typedef struct {
    logic [31:0] rdata;
    logic err, to;
    int cyc;
  } exp_t;
  cmd_t plan[$], tq[$], cur, pend, nx;
  exp_t sq[$], ex, got;
  logic have_pend = 0;
  int cyc = 0, k = 0, n_cmp = 0, n_bad = 0, alen;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
      input logic [3:0] strb, input int w, input logic err, input logic [31:0] rdata, input int gap);
    mk.wr = wr; mk.addr = addr; mk.wdata = wdata; mk.strb = strb;
    mk.w = w; mk.err = err; mk.rdata = rdata; mk.gap = gap;
  endfunction
  always @(posedge pclk) cyc++;
  always @(negedge pclk) begin
    if (!preset) begin
      tq.delete();
      sq.delete();
      have_pend = 0;
      cmd_valid = 0;
      pready = 0;
      pslverr = 0;
      prdata = 0;
    end else begin
      if (psel && !penable) begin
        if (tq.size() == 0) chk("setup_without_command", 1, 0);
        else cur = tq.pop_front();
        k = 0;
      end
      if (psel) begin
        chk("paddr", paddr, cur.addr);
        chk("pwrite", pwrite, cur.wr);
        chk("pwdata", pwdata, cur.wr ? cur.wdata : 0);
        chk("pstrb", pstrb, cur.wr ? cur.strb : 0);
        chk("pprot", pprot, PR);
      end
      if (psel && penable) begin
        alen = cur.w < TO ? cur.w : TO - 1;
        chk("access_overrun", k <= alen, 1);
        pready = k == cur.w;
        pslverr = pready ? cur.err : 1'($urandom);
        prdata = pready ? cur.rdata : $urandom;
        k++;
      end else begin
        pready = 1'($urandom);
        pslverr = 1'($urandom);
        prdata = $urandom;
      end
      if (!have_pend && plan.size() > 0) begin
        nx = plan[0];
        if (nx.gap > 0) begin
          nx.gap--;
          plan[0] = nx;
        end else begin
          pend = plan.pop_front();
          have_pend = 1;
        end
      end
      cmd_valid = have_pend;
      cmd_write = have_pend ? pend.wr : 1'($urandom);
      cmd_addr = have_pend ? pend.addr : $urandom;
      cmd_wdata = have_pend ? pend.wdata : $urandom;
      cmd_strb = have_pend ? pend.strb : 4'($urandom);
      #1;
      if (have_pend && cmd_ready) begin
        tq.push_back(pend);
        alen = pend.w + 1 < TO ? pend.w + 1 : TO;
        ex.to = pend.w >= TO;
        ex.err = ex.to ? 1'b1 : pend.err;
        ex.rdata = (ex.to || pend.wr) ? 32'h0 : pend.rdata;
        ex.cyc = cyc + alen + 2;
        sq.push_back(ex);
        have_pend = 0;
      end
    end
  end
  always @(negedge pclk) begin
    if (preset && rsp_valid) begin
      if (sq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        got = sq.pop_front();
        chk("rsp_rdata", rsp_rdata, got.rdata);
        chk("rsp_err", rsp_err, got.err);
        chk("rsp_timeout", rsp_timeout, got.to);
        chk("rsp_cycle", cyc, got.cyc);
      end
    end
  end
  initial begin
    preset = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
    pready = 0; pslverr = 0; prdata = 0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pprot", pprot, PR);
    @(posedge pclk);
    #2 preset = 1;
    plan.push_back(mk(1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 1));
    plan.push_back(mk(0, 32'h44, 32'h0, 4'hF, 3, 0, 32'h12345678, 2));
    plan.push_back(mk(1, 32'h48, 32'h11111111, 4'h3, 0, 0, 32'h0, 2));
    plan.push_back(mk(1, 32'h4C, 32'h22222222, 4'hC, 0, 0, 32'h0, 0));
    plan.push_back(mk(0, 32'h50, 32'h0, 4'h0, 100, 0, 32'h0, 2));
    plan.push_back(mk(0, 32'h54, 32'h0, 4'h0, 2, 1, 32'hA5, 2));
    plan.push_back(mk(0, 32'h58, 32'h0, 4'h0, 3, 1, 32'h5A, 0));
    for (int i = 0; i < 300; i++)
      plan.push_back(mk(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 5),
        $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0));
    for (int i = 0; i < 20000 && (plan.size() > 0 || have_pend || sq.size() > 0); i++) @(posedge pclk);
    chk("drain_left", plan.size() + sq.size() + int'(have_pend), 0);
    repeat (3) @(posedge pclk);
    plan.push_back(mk(0, 32'h60, 32'h0, 4'h0, 100, 0, 32'h0, 0));
    for (int i = 0; i < 50 && !(psel && penable); i++) @(negedge pclk);
    chk("reset_test_reached_access", psel && penable, 1);
    @(posedge pclk);
    #2 preset = 0;
    #1;
    chk("async_psel", psel, 0);
    chk("async_penable", penable, 0);
    @(posedge pclk);
    #2 preset = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      chk("post_reset_rsp_valid", rsp_valid, 0);
    end
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_psel", psel, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
